// File: rtl/compare_match_scorer_if.sv
// rtl/compare_match_scorer_if.sv - comparator sample / match score bundle for compare_match_scorer
interface compare_match_scorer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             sample_valid;
  logic             a_big;
  logic             b_big;
  logic             equal;
  logic [CNT_W-1:0] a_score;
  logic [CNT_W-1:0] b_score;
  logic [CNT_W-1:0] tie_count;
  logic [CNT_W-1:0] round_idx;
  logic             busy;
  logic             done;
  logic [1:0]       winner;
  logic             err;

  // Master drives control and comparator samples, observes the score
  modport master (
    output start, sample_valid, a_big, b_big, equal,
    input  a_score, b_score, tie_count, round_idx, busy, done, winner, err
  );

  // Slave is the scorer itself
  modport slave (
    input  start, sample_valid, a_big, b_big, equal,
    output a_score, b_score, tie_count, round_idx, busy, done, winner, err
  );
endinterface

// File: rtl/compare_match_scorer.sv
// rtl/compare_match_scorer.sv - best-of-ROUNDS match scorer fed by a one-hot comparator result
module compare_match_scorer #(
  parameter int ROUNDS = 5,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  compare_match_scorer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A side has won outright once it holds a strict majority of all rounds
  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(ROUNDS / 2 + 1);
  localparam logic [CNT_W-1:0] ROUNDS_C = CNT_W'(ROUNDS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] a_q, a_d;
  logic [CNT_W-1:0] b_q, b_d;
  logic [CNT_W-1:0] tie_q, tie_d;
  logic [CNT_W-1:0] rnd_q, rnd_d;
  logic [1:0]       winner_q, winner_d;
  logic             err_q, err_d;
  logic             busy_q;
  logic             done_q;

  // Next state, score updates and the early/round-limit decision on the new counts
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    tie_d    = tie_q;
    rnd_d    = rnd_q;
    winner_d = winner_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A sample arriving alongside start is dropped; only the clear happens
        if (bus.start) begin
          state_d  = S_PLAY;
          a_d      = '0;
          b_d      = '0;
          tie_d    = '0;
          rnd_d    = '0;
          winner_d = 2'b00;
          err_d    = 1'b0;
        end
      end
      S_PLAY: begin
        if (bus.sample_valid) begin
          case ({bus.a_big, bus.b_big, bus.equal})
            3'b100: begin
              a_d   = a_q + 1'b1;
              rnd_d = rnd_q + 1'b1;
            end
            3'b010: begin
              b_d   = b_q + 1'b1;
              rnd_d = rnd_q + 1'b1;
            end
            3'b001: begin
              tie_d = tie_q + 1'b1;
              rnd_d = rnd_q + 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
        if (a_d >= WIN_C) begin
          state_d  = S_DONE;
          winner_d = 2'b01;
        end else if (b_d >= WIN_C) begin
          state_d  = S_DONE;
          winner_d = 2'b10;
        end else if (rnd_d == ROUNDS_C) begin
          state_d = S_DONE;
          if (a_d > b_d) begin
            winner_d = 2'b01;
          end else if (b_d > a_d) begin
            winner_d = 2'b10;
          end else begin
            winner_d = 2'b11;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; busy/done follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      tie_q    <= '0;
      rnd_q    <= '0;
      winner_q <= 2'b00;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tie_q    <= tie_d;
      rnd_q    <= rnd_d;
      winner_q <= winner_d;
      err_q    <= err_d;
      busy_q   <= (state_d == S_PLAY);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign bus.a_score   = a_q;
  assign bus.b_score   = b_q;
  assign bus.tie_count = tie_q;
  assign bus.round_idx = rnd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.winner    = winner_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_compare_match_scorer.sv
// tb/tb_compare_match_scorer.sv - self-checking bench for compare_match_scorer
module tb_compare_match_scorer;

  localparam int ROUNDS = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;

  compare_match_scorer_if #(.CNT_W(CNT_W)) bus ();

  compare_match_scorer #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic [2:0] pat;
    int         ea;
    int         eb;
    int         et;
    int         er;
    logic       ebusy;
    logic       edone;
    logic [1:0] ew;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];
  int   n_tests;
  int   n_fail;

  // Behavioural reference: plain integers and match flags
  int   m_a, m_b, m_t, m_r, m_w;
  bit   m_err, m_in_match, m_over;

  function automatic vec_t mk(logic r, logic s, logic v, logic [2:0] p,
                              int a, int b, int t, int rn,
                              logic bs, logic dn, logic [1:0] w, logic e);
    vec_t x;
    x.rst = r; x.start = s; x.valid = v; x.pat = p;
    x.ea = a; x.eb = b; x.et = t; x.er = rn;
    x.ebusy = bs; x.edone = dn; x.ew = w; x.eerr = e;
    return x;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_t = 0; m_r = 0; m_w = 0;
    m_err = 1'b0; m_in_match = 1'b0; m_over = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic v, input logic [2:0] p);
    if (r) begin
      model_reset();
    end else if (!m_in_match && s) begin
      m_a = 0; m_b = 0; m_t = 0; m_r = 0; m_w = 0; m_err = 1'b0;
      m_in_match = 1'b1; m_over = 1'b0;
    end else if (m_in_match && v) begin
      if ($countones(p) == 1) begin
        if (p == 3'b100) m_a++;
        else if (p == 3'b010) m_b++;
        else m_t++;
        m_r++;
        if (m_a > ROUNDS / 2) m_w = 1;
        else if (m_b > ROUNDS / 2) m_w = 2;
        else if (m_r == ROUNDS) m_w = (m_a > m_b) ? 1 : (m_b > m_a) ? 2 : 3;
        if (m_w != 0) begin
          m_in_match = 1'b0;
          m_over = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [2:0] p);
    rst = r;
    bus.start = s;
    bus.sample_valid = v;
    {bus.a_big, bus.b_big, bus.equal} = p;
  endtask

  task automatic check(input string name, input int idx, input int a, input int b, input int t,
                       input int rn, input logic bs, input logic dn, input logic [1:0] w, input logic e);
    n_tests++;
    if (int'(bus.a_score) != a || int'(bus.b_score) != b || int'(bus.tie_count) != t ||
        int'(bus.round_idx) != rn || bus.busy !== bs || bus.done !== dn ||
        bus.winner !== w || bus.err !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got a=%0d b=%0d t=%0d r=%0d busy=%0b done=%0b w=%0d err=%0b, exp a=%0d b=%0d t=%0d r=%0d busy=%0b done=%0b w=%0d err=%0b",
               name, idx, bus.a_score, bus.b_score, bus.tie_count, bus.round_idx, bus.busy,
               bus.done, bus.winner, bus.err, a, b, t, rn, bs, dn, w, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 3'b000);

    // Directed sequence: inputs for one cycle, then expected registered outputs
    tbl.push_back(mk(1,0,0,3'b000, 0,0,0,0, 0,0,2'd0,0));
    // early win for A, later sample ignored in DONE
    tbl.push_back(mk(0,1,0,3'b000, 0,0,0,0, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b100, 1,0,0,1, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b100, 2,0,0,2, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b100, 3,0,0,3, 0,1,2'd1,0));
    tbl.push_back(mk(0,0,1,3'b010, 3,0,0,3, 0,1,2'd1,0));
    // round limit, B ahead
    tbl.push_back(mk(0,1,0,3'b000, 0,0,0,0, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b100, 1,0,0,1, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b010, 1,1,0,2, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 1,1,1,3, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 1,1,2,4, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b010, 1,2,2,5, 0,1,2'd2,0));
    // all ties -> draw
    tbl.push_back(mk(0,1,0,3'b000, 0,0,0,0, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 0,0,1,1, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 0,0,2,2, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,0,3'b100, 0,0,2,2, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 0,0,3,3, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 0,0,4,4, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b001, 0,0,5,5, 0,1,2'd3,0));
    // malformed samples, sticky err; then reset mid-match
    tbl.push_back(mk(0,1,0,3'b000, 0,0,0,0, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b000, 0,0,0,0, 1,0,2'd0,1));
    tbl.push_back(mk(0,0,1,3'b110, 0,0,0,0, 1,0,2'd0,1));
    tbl.push_back(mk(0,0,1,3'b100, 1,0,0,1, 1,0,2'd0,1));
    tbl.push_back(mk(0,0,1,3'b100, 2,0,0,2, 1,0,2'd0,1));
    tbl.push_back(mk(1,0,1,3'b100, 0,0,0,0, 0,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b100, 0,0,0,0, 0,0,2'd0,0));
    // start ignored in PLAY; start+sample from DONE clears and drops the sample
    tbl.push_back(mk(0,1,0,3'b000, 0,0,0,0, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b111, 0,0,0,0, 1,0,2'd0,1));
    tbl.push_back(mk(0,0,1,3'b100, 1,0,0,1, 1,0,2'd0,1));
    tbl.push_back(mk(0,1,0,3'b000, 1,0,0,1, 1,0,2'd0,1));
    tbl.push_back(mk(0,1,1,3'b100, 2,0,0,2, 1,0,2'd0,1));
    tbl.push_back(mk(0,0,1,3'b100, 3,0,0,3, 0,1,2'd1,1));
    tbl.push_back(mk(0,1,1,3'b100, 0,0,0,0, 1,0,2'd0,0));
    tbl.push_back(mk(0,0,1,3'b010, 0,1,0,1, 1,0,2'd0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].valid, tbl[i].pat);
      @(posedge clk);
      #1;
      check("directed", i, tbl[i].ea, tbl[i].eb, tbl[i].et, tbl[i].er,
            tbl[i].ebusy, tbl[i].edone, tbl[i].ew, tbl[i].eerr);
    end

    // Randomized play against the reference model
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      logic       r, s, v;
      logic [2:0] p;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) p = 3'($urandom_range(0, 7));
      else p = 3'b001 << $urandom_range(0, 2);
      drive(r, s, v, p);
      @(posedge clk);
      #1;
      model_step(r, s, v, p);
      check("random", i, m_a, m_b, m_t, m_r, m_in_match, m_over, 2'(m_w), m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
